// File: rtl/fminmax_reduce_if.sv
// -----------------------------------------------------------------------------
// fminmax_reduce_if
//
// Purpose: groups the element stream and result stream of fminmax_reduce into
// one bundle. The element side and the result side each use a valid/ready
// handshake.
//
// Signals (W = 1+EXP_W+MAN_W, IDX_W = $clog2(MAX_LEN)):
//   in_valid   producer -> unit   element valid
//   in_ready   unit -> producer   unit accepts element
//   in_data    producer -> unit   element {sign, exp, man}
//   in_last    producer -> unit   element closes the vector
//   mode       producer -> unit   0 = min, 1 = max (first element only)
//   out_valid  unit -> consumer   result valid
//   out_ready  consumer -> unit   consumer accepts result
//   out_data   unit -> consumer   selected element
//   out_index  unit -> consumer   0-based position of selected element
//   out_nan    unit -> consumer   every element of the vector was NaN
//   out_trunc  unit -> consumer   vector cut at MAX_LEN without in_last
//
// Modports: master = producer/consumer side, slave = reduction unit.
// -----------------------------------------------------------------------------
interface fminmax_reduce_if #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MAX_LEN = 16
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int IDX_W = $clog2(MAX_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_nan;
    logic             out_trunc;

    modport master (
        output in_valid, in_data, in_last, mode, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_nan, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_last, mode, out_ready,
        output in_ready, out_valid, out_data, out_index, out_nan, out_trunc
    );
endinterface

// File: rtl/fminmax_reduce.sv
// -----------------------------------------------------------------------------
// fminmax_reduce
//
// Purpose: streaming floating-point min/max reduction. Elements of a vector
// arrive one per cycle. The unit keeps a running best element and its index.
// When the vector closes, it presents the winning element, its index and
// status flags, and holds them until the consumer takes them.
//
// Parameters:
//   EXP_W    exponent field width
//   MAN_W    mantissa field width (element width W = 1+EXP_W+MAN_W)
//   MAX_LEN  maximum elements per vector (>= 2)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fminmax_reduce_if.slave (element stream in, result stream out)
//
// Ordering: NaNs never win. A NaN accumulator is always replaced by a non-NaN
// element. Non-NaN values are compared through a monotonic unsigned key, so
// -0 < +0 and subnormals/infinities order naturally. Ties keep the earlier
// index. An all-NaN vector reports the canonical quiet NaN at index 0.
// -----------------------------------------------------------------------------
module fminmax_reduce #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    fminmax_reduce_if.slave  bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int IDX_W = $clog2(MAX_LEN);
    // The count must be able to reach MAX_LEN itself, so it is one bit wider
    // than the index when MAX_LEN is a power of two.
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [W-1:0]     QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic f_is_nan(input logic [W-1:0] x);
        return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    // Map sign-magnitude to an unsigned key that orders like the real value:
    // negatives are bit-inverted, and positives get the MSB set so they sit
    // above every negative.
    function automatic logic [W-1:0] f_key(input logic [W-1:0] x);
        return x[W-1] ? ~x : {1'b1, x[W-2:0]};
    endfunction

    // -------------------------------------------------------------------------
    // State and storage
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic               r_acc_nan;

    logic [W-1:0]       r_out_data;
    logic [IDX_W-1:0]   r_out_index;
    logic               r_out_nan;
    logic               r_out_trunc;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_take;
    logic               w_elem_nan;
    logic [W-1:0]       w_key_elem;
    logic [W-1:0]       w_key_acc;
    logic               w_better;
    logic               w_close;

    logic [W-1:0]       w_acc_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_nan_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // in_ready depends only on state and rst. It is low in DONE so that the
    // result drains before the next vector's first element is accepted.
    assign w_in_ready  = !rst && (r_state != S_DONE);
    assign w_out_valid = (r_state == S_DONE);
    assign w_take      = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_nan   = r_out_nan;
    assign bus.out_trunc = r_out_trunc;

    // -------------------------------------------------------------------------
    // Compare element against accumulator
    // -------------------------------------------------------------------------
    assign w_elem_nan = f_is_nan(bus.in_data);
    assign w_key_elem = f_key(bus.in_data);
    assign w_key_acc  = f_key(r_acc);

    always_comb begin
        w_better = 1'b0;
        if (w_elem_nan) begin
            w_better = 1'b0;
        end else if (r_acc_nan) begin
            w_better = 1'b1;
        end else if (r_mode) begin
            w_better = (w_key_elem > w_key_acc);
        end else begin
            w_better = (w_key_elem < w_key_acc);
        end
    end

    // Next accumulator contents, assuming the element is accepted this cycle.
    always_comb begin
        w_acc_nxt = r_acc;
        w_idx_nxt = r_idx;
        w_nan_nxt = r_acc_nan;
        w_cnt_nxt = r_cnt;
        if (r_state == S_IDLE) begin
            w_acc_nxt = bus.in_data;
            w_idx_nxt = '0;
            w_nan_nxt = w_elem_nan;
            w_cnt_nxt = CNT_W'(1);
        end else begin
            if (w_better) begin
                w_acc_nxt = bus.in_data;
                w_idx_nxt = r_cnt[IDX_W-1:0];
                w_nan_nxt = 1'b0;
            end
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_close = w_take && (bus.in_last || (w_cnt_nxt == CNT_MAX));

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_take) begin
                    w_state_nxt = w_close ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers: mode, element count, result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_nan   <= 1'b0;
            r_out_trunc <= 1'b0;
        end else begin
            if (w_take) begin
                if (r_state == S_IDLE) begin
                    r_mode <= bus.mode;
                end
                r_cnt <= w_close ? '0 : w_cnt_nxt;
            end
            if (w_close) begin
                r_out_data  <= w_nan_nxt ? QNAN : w_acc_nxt;
                r_out_index <= w_nan_nxt ? '0 : w_idx_nxt;
                r_out_nan   <= w_nan_nxt;
                r_out_trunc <= !bus.in_last;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator datapath (reloaded by every first element, so no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_acc     <= w_acc_nxt;
            r_idx     <= w_idx_nxt;
            r_acc_nan <= w_nan_nxt;
        end
    end
endmodule

// File: doc/fminmax_reduce.md
# fminmax_reduce

Streaming floating-point min/max reduction unit for the FPU datapath. Accepts a vector of floats one element per cycle over a valid/ready handshake and returns the minimum or maximum, the index of the winning element, and status flags once the vector's last element arrives. It is a parametrised, sequential generalisation of the two-operand float compare/select. Format width and maximum vector length are configurable. It adds selectable min/max mode, NaN handling, signed-zero ordering and argmin/argmax.

## Interface
Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; element width W = 1+EXP_W+MAN_W.
- MAX_LEN, 16, maximum elements per vector (≥2); IDX_W = $clog2(MAX_LEN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  element valid.
- in_ready  out  1  unit accepts element.
- in_data  in  W  element {sign, exp, man}.
- in_last  in  1  element is last of vector.
- mode  in  1  0 = min, 1 = max; sampled with first element of a vector only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  selected element.
- out_index  out  IDX_W  position of selected element in vector (0-based).
- out_nan  out  1  every element of vector was NaN.
- out_trunc  out  1  vector cut at MAX_LEN without in_last.

## Operation
- States: IDLE (no vector open), ACC (vector open), DONE (result held).
- Handshake: element transfers when in_valid && in_ready; result transfers when out_valid && out_ready. in_ready = 1 in IDLE and ACC, 0 in DONE.
- IDLE + transfer: latch mode, load accumulator with element, best_idx = 0, count = 1; go to ACC. If in_last, go to DONE instead.
- ACC + transfer: compare element with accumulator and replace if strictly better; count++. Go to DONE if in_last or count reaches MAX_LEN (in the latter case without in_last, set trunc).
- DONE: out_valid = 1, outputs stable until out_ready. On handshake return to IDLE.
- Ordering key: NaN (exp all ones, man ≠ 0) is excluded. For non-NaN, key = sign ? ~x : x with MSB set, compared unsigned. Consequences: −0 < +0; subnormals and ±inf are ordered correctly.
- "Better": smaller key in min mode, larger in max mode. Ties keep the earlier index.
- NaN: a non-NaN element always replaces a NaN accumulator. A NaN element never replaces. If the whole vector is NaN, out_data = canonical quiet NaN {0, all ones, 1, 0…}, out_index = 0 and out_nan = 1.
- Non-NaN results are passed bit-exact; no rounding or normalisation.

## Timing
- Reset values: in_ready = 0 during the reset cycle, 1 from the first cycle after; out_valid = 0; out_data = 0; out_index = 0; out_nan = 0; out_trunc = 0; state = IDLE; count = 0.
- Throughput: 1 element/cycle while in ACC or IDLE.
- Latency: out_valid rises the cycle after the handshake of the closing element (last, or MAX_LEN-th).
- Between vectors: at least one bubble cycle. DONE holds in_ready low and the result drains before the next first element is accepted. No element is accepted in the same cycle as the out handshake.
- in_valid must not depend on in_ready. Unaccepted in_data, in_last and mode are ignored.
- rst mid-vector or in DONE: the partial vector and pending result are discarded and all state returns to reset values next cycle.
- A single-element vector (first element with in_last) gives a result equal to the input at index 0, one cycle later.

## Test plan
- Max mode, vector {0x3F800000 (1.0), 0xC0000000 (−2.0), 0x40400000 (3.0), 0x40000000 (2.0)} with last on the 4th element → out_data 0x40400000, out_index 2, out_valid in the cycle after the 4th element.
- Min mode, {0x00000000 (+0), 0x80000000 (−0), 0x00000001 (min subnormal)} → 0x80000000, index 1. Repeat with {+0, +0} → index 0, testing the tie rule.
- NaN mix, min mode, {0x7FC00000, 0xFF800000 (−inf), 0x7FC00001} → 0xFF800000, index 1, out_nan 0. All-NaN vector → 0x7FC00000, index 0, out_nan 1.
- Truncation with MAX_LEN=16: 20 elements sent with no in_last, value = element index as float → result after 16th element, out_trunc 1, in_ready 0 while out_ready is held low for 5 cycles, result stable. Next vector starts from element 17.
- Back-pressure and mode switch: vector A in max mode, vector B in min mode, out_ready low for 3 cycles between them → each result uses its own mode and no elements are lost.
- Reset mid-vector after 2 elements, then a fresh 1-element vector {0x42280000} → out 0x42280000, index 0, no residue from the aborted vector.
